// File: rtl/mem_sram_responder_if.sv
// MEM-protocol bus bundle (req/gnt/valid) between a core-side master and a memory responder.
// The master drives the request fields; the slave drives grant and the in-order response.
interface mem_sram_responder_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  req;
  logic                  gnt;
  logic                  valid;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, valid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, valid, rdata
  );
endinterface

// File: rtl/mem_sram_responder.sv
// Word-organised SRAM behind a MEM-protocol slave: fixed response latency, bounded
// outstanding requests via grant backpressure, strictly in-order responses.
module mem_sram_responder #(
  parameter int unsigned                     LOCAL_DATA_WIDTH = 32,
  parameter int unsigned                     LOCAL_ADDR_WIDTH = 32,
  parameter logic [LOCAL_ADDR_WIDTH-1:0]     BASE_ADDR        = 32'h0000_0000,
  parameter int unsigned                     DEPTH            = 1024,
  parameter int unsigned                     LATENCY          = 1,
  parameter int unsigned                     MAX_OUTSTANDING  = 2,
  parameter logic [LOCAL_DATA_WIDTH-1:0]     ERR_RDATA        = 32'hDEAD_BEEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_sram_responder_if.slave mem
);

  localparam int unsigned DW    = LOCAL_DATA_WIDTH;
  localparam int unsigned AW    = LOCAL_ADDR_WIDTH;
  localparam int unsigned BE_W  = DW / 8;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept_c;
  logic [AW-1:0]    off_c;
  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;
  logic [DW-1:0]    rsp_data_c;

  logic [DW-1:0]      sram [DEPTH];
  logic [LATENCY-1:0] pipe_vld_q;
  logic [DW-1:0]      pipe_data_q [LATENCY];

  // Grant depends only on the registered count, so a retiring response frees its slot next cycle.
  assign mem.gnt  = !rst_i && (cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign accept_c = mem.req && mem.gnt;

  // Address decode: offsets below the base wrap to large values and fall out of range.
  always_comb begin
    off_c      = mem.addr - BASE_ADDR;
    in_range_c = (off_c >> (IDX_W + 2)) == '0;
    idx_c      = off_c[IDX_W+1:2];
  end

  // Response payload: read data, error pattern for unmapped reads, zero for writes.
  always_comb begin
    rsp_data_c = '0;
    if (!mem.we) begin
      rsp_data_c = in_range_c ? sram[idx_c] : ERR_RDATA;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (accept_c && mem.we && in_range_c) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mem.be[b]) begin
          sram[idx_c][8*b +: 8] <= mem.wdata[8*b +: 8];
        end
      end
    end
  end

  // Fixed-latency response pipe; reset discards everything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= accept_c;
      pipe_data_q[0] <= accept_c ? rsp_data_c : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  assign mem.valid = pipe_vld_q[LATENCY-1];
  assign mem.rdata = pipe_data_q[LATENCY-1];

  always_comb begin
    cnt_d = cnt_q + CNT_W'(accept_c) - CNT_W'(mem.valid);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  a_cnt_max : assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q <= CNT_W'(MAX_OUTSTANDING));

  a_cnt_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem.valid && (cnt_q == '0)));

endmodule

// File: tb/tb_mem_sram_responder.sv
// Directed bench for mem_sram_responder: three configurations (latency 1/4/3) checked every
// cycle against a transaction-level model, plus literal expectations for the key scenarios.
module tb_mem_sram_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] ERR   = 32'hDEAD_BEEF;

  typedef struct {
    int          k;
    int          cyc;
    logic [31:0] data;
  } obs_t;

  typedef struct {
    int          due;
    bit          dc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [2:0]       req, we, gnt, valid;
  logic [2:0][31:0] addr, wdata, rdata;
  logic [2:0][3:0]  be;

  obs_t obs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got 0x%08h, want 0x%08h (cycle %0d)", k, name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT  = (g == 0) ? 1 : (g == 1) ? 4 : 3;
    localparam int MAXO = (g == 0) ? 1 : 2;

    mem_sram_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    assign bus.req   = req[g];
    assign bus.we    = we[g];
    assign bus.addr  = addr[g];
    assign bus.be    = be[g];
    assign bus.wdata = wdata[g];
    assign gnt[g]    = bus.gnt;
    assign valid[g]  = bus.valid;
    assign rdata[g]  = bus.rdata;

    mem_sram_responder #(
      .LOCAL_DATA_WIDTH (32),
      .LOCAL_ADDR_WIDTH (32),
      .BASE_ADDR        (BASE),
      .DEPTH            (DEPTH),
      .LATENCY          (LAT),
      .MAX_OUTSTANDING  (MAXO),
      .ERR_RDATA        (ERR)
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .mem   (bus)
    );

    // Transaction model: pending responses keyed by due cycle, memory as a sparse word map.
    exp_t        pend[$];
    logic [31:0] ref_mem [int];

    always @(negedge clk) begin : model
      exp_t        e;
      bit          exp_gnt;
      bit          inr;
      int          idx;
      logic [31:0] off;
      logic [31:0] word;
      if (rst) begin
        pend.delete();
        chk(g, "rst_gnt", 32'(gnt[g]), 32'd0);
        chk(g, "rst_valid", 32'(valid[g]), 32'd0);
        chk(g, "rst_rdata", rdata[g], 32'd0);
      end else begin
        exp_gnt = pend.size() < MAXO;
        chk(g, "gnt", 32'(gnt[g]), 32'(exp_gnt));
        if (pend.size() != 0 && pend[0].due == cyc) begin
          e = pend.pop_front();
          chk(g, "valid", 32'(valid[g]), 32'd1);
          if (!e.dc) chk(g, "rdata", rdata[g], e.data);
          obs_q.push_back('{g, cyc, rdata[g]});
        end else begin
          chk(g, "idle_valid", 32'(valid[g]), 32'd0);
          chk(g, "idle_rdata", rdata[g], 32'd0);
        end
        if (req[g] && exp_gnt) begin
          off  = addr[g] - BASE;
          inr  = off < DEPTH * 4;
          idx  = inr ? int'(off / 4) : 0;
          word = (inr && ref_mem.exists(idx)) ? ref_mem[idx] : 32'hxxxx_xxxx;
          if (we[g]) begin
            if (inr) begin
              for (int b = 0; b < 4; b++) begin
                if (be[g][b]) word[8*b +: 8] = wdata[g][8*b +: 8];
              end
              ref_mem[idx] = word;
            end
            pend.push_back('{cyc + LAT, 1'b0, 32'h0});
          end else begin
            pend.push_back('{cyc + LAT, inr && $isunknown(word), inr ? word : ERR});
          end
        end
      end
    end
  end

  // Present a request and hold it until granted; returns at posedge+1 after the grant edge.
  task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input bit keep, output int gc);
    bit got = 1'b0;
    req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    gc = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (gnt[k]) begin
        got = 1'b1;
        gc  = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) req[k] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL dut%0d grant_timeout: got no grant, want grant within 40 cycles", k);
    end
  endtask

  task automatic collect(input int k, output logic [31:0] d, output int rc);
    obs_t o;
    d  = 32'hxxxx_xxxx;
    rc = -1;
    for (int i = 0; i < 40 && obs_q.size() == 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (obs_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d resp_timeout: got no response, want one within 40 cycles", k);
    end else begin
      o = obs_q.pop_front();
      chk(k, "resp_port", 32'(o.k), 32'(k));
      d  = o.data;
      rc = o.cyc;
    end
  endtask

  task automatic write_word(input int k, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    int          gc, rc;
    logic [31:0] r;
    issue(k, 1'b1, a, b, d, 1'b0, gc);
    collect(k, r, rc);
    chk(k, "wr_rdata_zero", r, 32'h0);
  endtask

  task automatic read_word(input int k, input logic [31:0] a, input string name, input logic [31:0] exp);
    int          gc, rc;
    logic [31:0] r;
    issue(k, 1'b0, a, 4'h0, 32'h0, 1'b0, gc);
    collect(k, r, rc);
    chk(k, name, r, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          gc, rc;
    int          gcs [4];
    int          rcs [4];
    logic [31:0] d;

    rst = 1'b1; req = '0; we = '0; addr = '0; be = '0; wdata = '0;

    // Reset held three cycles with req asserted.
    req = 3'b111;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk(k, "t1_gnt_in_reset", 32'(gnt[k]), 32'd0);
        chk(k, "t1_valid_in_reset", 32'(valid[k]), 32'd0);
        chk(k, "t1_rdata_in_reset", rdata[k], 32'd0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; req = '0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk(k, "t1_gnt_after_reset", 32'(gnt[k]), 32'd1);
    @(posedge clk); #1;

    // Latency 1: write then read, one cycle grant-to-valid.
    issue(0, 1'b1, BASE + 32'h10, 4'hF, 32'h1234_5678, 1'b0, gc);
    collect(0, d, rc);
    chk(0, "t2_wr_latency", 32'(rc - gc), 32'd1);
    chk(0, "t2_wr_rdata", d, 32'h0);
    issue(0, 1'b0, BASE + 32'h10, 4'h0, 32'h0, 1'b0, gc);
    collect(0, d, rc);
    chk(0, "t2_rd_latency", 32'(rc - gc), 32'd1);
    chk(0, "t2_rd_rdata", d, 32'h1234_5678);

    // Byte enables, including an all-zero mask that must still respond.
    write_word(0, BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
    write_word(0, BASE + 32'h20, 4'h1, 32'h0000_00AA);
    read_word(0, BASE + 32'h20, "t3_be0001", 32'hFFFF_FFAA);
    write_word(0, BASE + 32'h20, 4'h8, 32'h5500_0000);
    read_word(0, BASE + 32'h20, "t3_be1000", 32'h55FF_FFAA);
    write_word(0, BASE + 32'h20, 4'h0, 32'h1111_1111);
    read_word(0, BASE + 32'h20, "t3_be0000", 32'h55FF_FFAA);

    // Backpressure on latency 4 / two outstanding, req held high across four reads.
    for (int i = 0; i < 4; i++) write_word(1, BASE + 32'(4 * i), 4'hF, 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 4; i++) issue(1, 1'b0, BASE + 32'(4 * i), 4'h0, 32'h0, i < 3, gcs[i]);
    for (int i = 0; i < 4; i++) begin
      collect(1, d, rcs[i]);
      chk(1, "t4_order_data", d, 32'hC0DE_0000 + 32'(i));
    end
    chk(1, "t4_grant1_offset", 32'(gcs[1] - gcs[0]), 32'd1);
    chk(1, "t4_grant2_offset", 32'(gcs[2] - gcs[0]), 32'd5);
    chk(1, "t4_grant3_offset", 32'(gcs[3] - gcs[0]), 32'd6);
    chk(1, "t4_valid0_offset", 32'(rcs[0] - gcs[0]), 32'd4);
    chk(1, "t4_valid1_offset", 32'(rcs[1] - gcs[0]), 32'd5);

    // Range boundaries on latency 1.
    write_word(0, BASE, 4'hF, 32'h5A5A_0000);
    write_word(0, BASE + 32'h3C, 4'hF, 32'h3C3C_3C3C);
    read_word(0, BASE + 32'h3C, "t5_last_word", 32'h3C3C_3C3C);
    read_word(0, BASE + DEPTH * 4, "t5_past_end", 32'hDEAD_BEEF);
    write_word(0, BASE + DEPTH * 4, 4'hF, 32'hFFFF_FFFF);
    read_word(0, BASE, "t5_word0_intact", 32'h5A5A_0000);
    read_word(0, BASE - 32'h4, "t5_below_base", 32'hDEAD_BEEF);

    // Reset with a write and a read in flight on latency 3.
    issue(2, 1'b1, BASE + 32'h8, 4'hF, 32'h600D_CAFE, 1'b1, gc);
    issue(2, 1'b0, BASE + 32'h8, 4'h0, 32'h0, 1'b0, gc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk(2, "t6_no_valid_after_reset", 32'(obs_q.size()), 32'd0);
    read_word(2, BASE + 32'h8, "t6_write_committed", 32'h600D_CAFE);

    repeat (6) @(posedge clk);
    chk(0, "final_no_stray_responses", 32'(obs_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
